// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        SKID = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0;
    localparam int unsigned PC_INCREMENT_DEFAULT = 1;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry word+pc holding register that parks a fetched word while decode stalls.
module fetch_skid_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_word,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic [DATA_WIDTH-1:0] word,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  full
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            full <= 1'b0;
            word <= '0;
            pc   <= '0;
        end else if (load) begin
            full <= 1'b1;
            word <= load_word;
            pc   <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues PCs to synchronous imem, owns the IF/ID register
// and a one-entry skid buffer, and tells next-PC logic when to recirculate.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(NOP_INSTR_DEFAULT),
    parameter int unsigned           PC_INCREMENT = PC_INCREMENT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  pc_hold,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [ADDR_WIDTH-1:0] if_id_npc,
    output logic                  if_id_valid
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INCREMENT);

    fetch_state_e          state_q, state_d;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;

    logic                  valid_d;
    logic [DATA_WIDTH-1:0] instr_d;
    logic [ADDR_WIDTH-1:0] npc_d;

    logic                  skid_load, skid_drain, skid_clear, skid_full;
    logic [DATA_WIDTH-1:0] skid_word;
    logic [ADDR_WIDTH-1:0] skid_pc;

    // A parked word blocks issue until it has been handed to decode; during
    // reset the buffer is being discarded, so only stall may hold the PC.
    assign imem_addr = instruction_address;
    assign pc_hold   = stall || (skid_full && !reset);
    assign imem_en   = !reset && !pc_hold;

    fetch_skid_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (skid_clear),
        .load_word (imem_data),
        .load_pc   (inflight_pc_q),
        .word      (skid_word),
        .pc        (skid_pc),
        .full      (skid_full)
    );

    always_comb begin
        state_d    = state_q;
        valid_d    = if_id_valid;
        instr_d    = if_id_instruction;
        npc_d      = if_id_npc;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_clear = 1'b0;

        if (flush) begin
            skid_clear = 1'b1;
            state_d    = RUN;
            valid_d    = 1'b0;
            instr_d    = NOP_INSTR;
        end else if (stall) begin
            if (state_q == RUN && inflight_q) begin
                skid_load = 1'b1;
                state_d   = SKID;
            end
        end else if (state_q == SKID) begin
            skid_drain = 1'b1;
            state_d    = RUN;
            valid_d    = 1'b1;
            instr_d    = skid_word;
            npc_d      = skid_pc + PC_STEP;
        end else if (inflight_q) begin
            valid_d = 1'b1;
            instr_d = imem_data;
            npc_d   = inflight_pc_q + PC_STEP;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= RUN;
            inflight_q        <= 1'b0;
            inflight_pc_q     <= '0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_npc         <= '0;
        end else begin
            state_q           <= state_d;
            inflight_q        <= imem_en && !flush;
            if (imem_en) begin
                inflight_pc_q <= instruction_address;
            end
            if_id_valid       <= valid_d;
            if_id_instruction <= instr_d;
            if_id_npc         <= npc_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/flush/reset traffic,
// checked against a queue-based model of fetched-but-undelivered PCs.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_address = '0;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        pc_hold;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_npc;
    logic        if_id_valid;

    always #5 clock = ~clock;

    fetch_stage #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .instruction_address(instruction_address),
        .imem_addr         (imem_addr),
        .imem_en           (imem_en),
        .imem_data         (imem_data),
        .stall             (stall),
        .flush             (flush),
        .pc_hold           (pc_hold),
        .if_id_instruction (if_id_instruction),
        .if_id_npc         (if_id_npc),
        .if_id_valid       (if_id_valid)
    );

    // Synchronous instruction memory: word at address a is a*4.
    logic [31:0] mem_addr_q = '0;
    always @(posedge clock) if (imem_en) mem_addr_q <= imem_addr;
    assign imem_data = mem_addr_q * 32'd4;

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Model: PCs fetched but not yet handed to decode, and whether the oldest
    // has been parked by a stall (it then blocks fetch until delivered).
    logic [31:0] pend[$];
    logic        parked = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_npc = '0;

    logic [31:0] pc = '0;
    logic        last_rst = 1'b1;
    logic        last_fl = 1'b0;
    logic        last_issue = 1'b0;
    logic [31:0] last_tgt = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic rst, input logic fl, input logic st, input logic [31:0] tgt);
        logic exp_hold, exp_issue;
        @(negedge clock);
        if (last_rst)        pc = '0;
        else if (last_fl)    pc = last_tgt;
        else if (last_issue) pc = pc + 32'd1;
        reset = rst;
        flush = fl;
        stall = st;
        instruction_address = pc;
        exp_hold  = st || (parked && !rst);
        exp_issue = !rst && !exp_hold;
        #1;
        check("pc_hold", {31'b0, pc_hold}, {31'b0, exp_hold});
        check("imem_en", {31'b0, imem_en}, {31'b0, exp_issue});
        check("imem_addr", imem_addr, pc);
        @(posedge clock);
        if (rst) begin
            pend.delete();
            parked  = 1'b0;
            m_valid = 1'b0;
            m_instr = '0;
            m_npc   = '0;
        end else if (fl) begin
            pend.delete();
            parked  = 1'b0;
            m_valid = 1'b0;
            m_instr = '0;
        end else if (st) begin
            if (pend.size() != 0) parked = 1'b1;
        end else if (pend.size() != 0) begin
            m_valid = 1'b1;
            m_instr = pend[0] * 32'd4;
            m_npc   = pend[0] + 32'd1;
            void'(pend.pop_front());
            parked  = 1'b0;
        end else begin
            m_valid = 1'b0;
        end
        if (exp_issue && !fl) pend.push_back(pc);
        #1;
        check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        check("if_id_instruction", if_id_instruction, m_instr);
        check("if_id_npc", if_id_npc, m_npc);
        last_rst   = rst;
        last_fl    = fl;
        last_issue = exp_issue;
        last_tgt   = tgt;
    endtask

    initial begin
        logic r, f, s;
        logic [31:0] t;

        // Reset then sequential fetch from 0
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t1_valid0", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("t1_i0", if_id_instruction, 32'd0);
        check("t1_n0", if_id_npc, 32'd1);
        check("t1_v0", {31'b0, if_id_valid}, 32'd1);
        step(0, 0, 0, 0);
        check("t1_i1", if_id_instruction, 32'd4);
        check("t1_n1", if_id_npc, 32'd2);
        step(0, 0, 0, 0);
        check("t1_i2", if_id_instruction, 32'd8);
        check("t1_n2", if_id_npc, 32'd3);

        // Stall three cycles with PC=5 in flight
        step(0, 1, 0, 32'd5);
        step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            check("t2_hold", {31'b0, pc_hold}, 32'd1);
            check("t2_ifid_held", {31'b0, if_id_valid}, 32'd0);
        end
        step(0, 0, 0, 0);
        check("t2_word5", if_id_instruction, 32'd20);
        check("t2_npc6", if_id_npc, 32'd6);
        check("t2_valid", {31'b0, if_id_valid}, 32'd1);
        step(0, 0, 0, 0);
        check("t2_bubble", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("t2_word6", if_id_instruction, 32'd24);
        check("t2_npc7", if_id_npc, 32'd7);

        // Flush with PC=9 in flight, jump to 40
        step(0, 1, 0, 32'd9);
        step(0, 0, 0, 0);
        step(0, 1, 0, 32'd40);
        check("t3_valid0", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("t3_no_word9", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("t3_target", if_id_instruction, 32'd160);
        check("t3_npc", if_id_npc, 32'd41);

        // Flush and stall together while a word is parked
        step(0, 0, 1, 0);
        step(0, 1, 1, 32'd60);
        check("t4_valid0", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t4_target", if_id_instruction, 32'd240);

        // Reset while parked with stall held
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check("t5_valid", {31'b0, if_id_valid}, 32'd0);
        check("t5_instr", if_id_instruction, 32'd0);
        check("t5_npc", if_id_npc, 32'd0);
        step(0, 0, 0, 0);
        check("t5_no_stale", {31'b0, if_id_valid}, 32'd0);
        step(0, 0, 0, 0);
        check("t5_first", if_id_npc, 32'd1);

        // PC wrap at all-ones
        step(0, 1, 0, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("t6_npc_wrap", if_id_npc, 32'd0);
        check("t6_valid", {31'b0, if_id_valid}, 32'd1);
        check("t6_instr", if_id_instruction, 32'hFFFF_FFFC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 2) == 0);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
            step(r, f, s, t);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
